// File: rtl/seq_divider8.sv
// seq_divider8: iterative unsigned restoring divider, one quotient bit per clock.
// Latency WIDTH cycles start->done (1 cycle on divide-by-zero); start is ignored while busy.
module seq_divider8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   pr;
  logic [CW-1:0]    cnt;
  logic             done_q;

  logic             accept;
  logic             zero_div;
  logic             last_iter;
  logic [WIDTH:0]   pr_shift;
  logic [WIDTH:0]   trial;
  logic             carry_raw;
  logic             carry;
  logic [WIDTH:0]   pr_nxt;
  logic [WIDTH-1:0] dsr_nxt;

  assign accept    = start && (state != RUN);
  assign zero_div  = (divisor == '0);
  assign last_iter = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // Trial subtraction in the same a + ~b + 1 form as the upstream subtractor.
  always_comb begin
    pr_shift           = {pr[WIDTH-1:0], dsr[WIDTH-1]};
    {carry_raw, trial} = {1'b0, pr_shift} + {1'b0, ~{1'b0, dvs}} + {{(WIDTH+1){1'b0}}, 1'b1};
    // A set top bit means the shifted value is at least 2^(WIDTH+1), always above the divisor.
    carry              = carry_raw | pr[WIDTH];
    pr_nxt             = carry ? trial : pr_shift;
    dsr_nxt            = {dsr[WIDTH-2:0], carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (accept) begin
          state_nxt = zero_div ? FIN : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_nxt = FIN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = done_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsr         <= '0;
      dvs         <= '0;
      pr          <= '0;
      cnt         <= '0;
      done_q      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (zero_div) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
          done_q      <= 1'b1;
        end else begin
          dsr         <= dividend;
          dvs         <= divisor;
          pr          <= '0;
          cnt         <= '0;
          div_by_zero <= 1'b0;
        end
      end else if (state == RUN) begin
        pr  <= pr_nxt;
        dsr <= dsr_nxt;
        cnt <= cnt + CW'(1);
        // Results are only published at completion so back-to-back starts keep the old ones visible.
        if (last_iter) begin
          quotient  <= dsr_nxt;
          remainder <= pr_nxt[WIDTH-1:0];
          done_q    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider8.sv
// Scoreboard bench for seq_divider8: driver pushes expected results, monitor checks them on done.
module tb_seq_divider8;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider8 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
        chk("div_by_zero", div_by_zero, mon_e.dbz);
        chk("done_latency_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    e.q   = (b == 0) ? 8'hFF : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dbz = (b == 0);
    e.cyc = cyc + 1 + ((b == 0) ? 0 : W);
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic wait_done(output int nbusy);
    int n;
    nbusy = 0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int exp_busy);
    int nb;
    issue(a, b);
    wait_done(nb);
    chk($sformatf("busy_cycles_%0d_%0d", a, b), nb, exp_busy);
    @(negedge clk);
  endtask

  initial begin
    #200_0000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nb;
    int nd;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    #1;
    chk("reset_outputs", {busy, done, quotient, remainder, div_by_zero}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 200/7 with full busy/done timing
    issue(8'd200, 8'd7);
    wait_done(nb);
    chk("busy_cycles_200_7", nb, 8);
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    chk("result_held_q", quotient, 28);
    chk("result_held_r", remainder, 4);

    op(8'd255, 8'd1, 8);
    op(8'd5, 8'd9, 8);
    op(8'd255, 8'd255, 8);

    // divide by zero, then a normal op clears the flag
    op(8'd77, 8'd0, 0);
    chk("dbz_held", div_by_zero, 1);
    op(8'd10, 8'd3, 8);
    chk("dbz_cleared", div_by_zero, 0);

    // start while busy is ignored
    issue(8'd100, 8'd10);
    repeat (2) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb);
    @(negedge clk);
    nd = 0;
    repeat (12) begin
      if (done === 1'b1) nd++;
      @(negedge clk);
    end
    chk("ignored_start_no_extra_done", nd, 0);

    // asynchronous reset mid-operation
    issue(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, done, quotient, remainder, div_by_zero}, 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("no_done_after_reset", nd, 0);
    op(8'd13, 8'd4, 8);

    // back-to-back: second start in the done cycle
    issue(8'd50, 8'd6);
    wait_done(nb);
    issue(8'd99, 8'd9);
    chk("b2b_busy", busy, 1);
    chk("b2b_done_dropped", done, 0);
    chk("b2b_prev_q_visible", quotient, 8);
    chk("b2b_prev_r_visible", remainder, 2);
    wait_done(nb);
    chk("b2b_busy_cycles", nb, 8);
    @(negedge clk);

    // random operand pairs, with some zero divisors mixed in
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = (i % 25 == 0) ? 8'd0 : W'($urandom_range(1, 255));
      op(ra, rb, (rb == 0) ? 0 : 8);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
